// File: rtl/seq_sym_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seq_sym_tx
// Symbol-sequence transmitter for the 4-bit symbol bus. On request it sends the
// frame 1,0,2,2,1,0 a programmable number of times, then returns to driving a
// non-matching idle symbol so the downstream sequence detector never fires
// spuriously.
//
// Build option:
//   SEQ_SYM_TX_OVERLAP_EN  - when defined, repeat frames reuse the trailing
//                            "1,0" of the previous frame and only send 2,2,1,0.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous, active-high reset
//   start  - transmit request, sampled only while idle
//   count  - number of frames to send, latched on an accepted start
//   abort  - terminates transmission at the next edge
//   x      - registered transmitted symbol
//   valid  - high while x carries a frame symbol
//   busy   - high for every cycle that carries a frame symbol
//   done   - one-cycle pulse with the final symbol of the final frame
// -----------------------------------------------------------------------------
module seq_sym_tx #(
   parameter int          CNT_W    = 4,
   parameter logic [3:0]  IDLE_SYM = 4'b1111
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic             abort,
   output logic [3:0]       x,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      IDLE,
      T1A,
      T0A,
      T2A,
      T2B,
      T1B,
      T0B
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [3:0]       x_q, x_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;

   // Symbol carried by each state; outputs are decoded from the next state and
   // registered so that every output is a flop.
   function automatic logic [3:0] symOf(input state_t s);
      logic [3:0] sym;
      sym = IDLE_SYM;
      case (s)
         T1A, T1B: sym = 4'd1;
         T0A, T0B: sym = 4'd0;
         T2A, T2B: sym = 4'd2;
         default:  sym = IDLE_SYM;
      endcase
      return sym;
   endfunction

   // Next-state logic: frame walk, frame-repeat counting, and abort override.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (start && (count != '0)) begin
               state_d = T1A;
               rem_d   = count;
            end
         end
         T1A: state_d = T0A;
         T0A: state_d = T2A;
         T2A: state_d = T2B;
         T2B: state_d = T1B;
         T1B: state_d = T0B;
         T0B: begin
            // The counter leaves at 1, so the decrement can never wrap.
            if (rem_q == CNT_W'(1)) begin
               state_d = IDLE;
               rem_d   = '0;
            end else begin
               rem_d = rem_q - CNT_W'(1);
`ifdef SEQ_SYM_TX_OVERLAP_EN
               // The detector's overlap path already holds the "1,0" just sent.
               state_d = T2A;
`else
               state_d = T1A;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            rem_d   = '0;
         end
      endcase

      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         rem_d   = '0;
      end
   end

   // Output decode of the upcoming state. done marks the T0B cycle of the
   // final frame; rem is still 1 there because it only decrements on exit.
   always_comb begin
      x_d     = symOf(state_d);
      valid_d = (state_d != IDLE);
      done_d  = (state_d == T0B) && (rem_d == CNT_W'(1));
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         x_q     <= IDLE_SYM;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         x_q     <= x_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign x     = x_q;
   assign valid = valid_q;
   assign busy  = valid_q;
   assign done  = done_q;

endmodule

// File: tb/tb_seq_sym_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_seq_sym_tx
// Scoreboard bench for seq_sym_tx. Stimulus pushes the hand-derived symbol
// stream into a queue; an independent monitor pops one entry per valid cycle,
// checks idle behaviour otherwise, and runs a 1,0,2,2,1,0 detector model.
// -----------------------------------------------------------------------------
module tb_seq_sym_tx;

`ifdef SEQ_SYM_TX_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic [3:0] count;
   logic [3:0] x;
   logic       valid;
   logic       busy;
   logic       done;

   seq_sym_tx dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .count (count),
      .abort (abort),
      .x     (x),
      .valid (valid),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] sym;
      logic       last;
   } exp_t;

   exp_t        sbq[$];
   int          checks    = 0;
   int          failures  = 0;
   int          zCount    = 0;
   int          doneCount = 0;
   logic [23:0] hist      = '1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   // Expected stream for n frames; repeat frames drop the leading 1,0 in the
   // overlap build.
   task automatic pushFrames(input int n);
      for (int f = 0; f < n; f++) begin
         if (f == 0 || !OVL) begin
            sbq.push_back('{sym: 4'd1, last: 1'b0});
            sbq.push_back('{sym: 4'd0, last: 1'b0});
         end
         sbq.push_back('{sym: 4'd2, last: 1'b0});
         sbq.push_back('{sym: 4'd2, last: 1'b0});
         sbq.push_back('{sym: 4'd1, last: 1'b0});
         sbq.push_back('{sym: 4'd0, last: (f == n - 1)});
      end
   endtask

   // One-cycle start pulse driven from a falling edge; returns on the falling
   // edge where the first symbol is on the bus.
   task automatic applyStimulus(input logic [3:0] n);
      pushFrames(int'(n));
      start = 1'b1;
      count = n;
      @(negedge clk);
      start = 1'b0;
      count = 4'hA;
   endtask

   // Bounded wait for the expected stream to be consumed and the DUT idle.
   task automatic waitIdle();
      for (int i = 0; i < 200; i++) begin
         if (sbq.size() == 0 && !busy) break;
         @(negedge clk);
      end
      checkOutput("drain_queue", sbq.size(), 0);
      checkOutput("drain_busy", int'(busy), 0);
      @(negedge clk);
   endtask

   // Monitor: samples shortly after each rising edge, consumes the scoreboard
   // on valid symbols and tracks detector hits and done pulses.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (rst) begin
         hist = '1;
      end else begin
         hist = {hist[19:0], x};
         if (hist == 24'h102210) zCount++;
         if (done) doneCount++;
         if (valid) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_symbol actual=%0d required=none", x);
            end else begin
               e = sbq.pop_front();
               checkOutput("symbol", int'(x), int'(e.sym));
               checkOutput("done", int'(done), int'(e.last));
               checkOutput("busy_with_valid", int'(busy), 1);
            end
         end else begin
            checkOutput("idle_symbol", int'(x), 15);
            checkOutput("idle_done", int'(done), 0);
            checkOutput("idle_busy", int'(busy), 0);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int z0;
      int d0;
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      count = 4'd0;
      #1;
      checkOutput("reset_x", int'(x), 15);
      checkOutput("reset_valid", int'(valid), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] single frame");
      z0 = zCount; d0 = doneCount;
      applyStimulus(4'd1);
      waitIdle();
      checkOutput("single_z", zCount - z0, 1);
      checkOutput("single_done", doneCount - d0, 1);

      $display("[TB] three frames");
      z0 = zCount; d0 = doneCount;
      applyStimulus(4'd3);
      waitIdle();
      checkOutput("three_z", zCount - z0, 3);
      checkOutput("three_done", doneCount - d0, 1);

      $display("[TB] zero count");
      d0 = doneCount;
      start = 1'b1;
      count = 4'd0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkOutput("zero_busy", int'(busy), 0);
         checkOutput("zero_x", int'(x), 15);
         @(negedge clk);
      end
      checkOutput("zero_done", doneCount - d0, 0);

      $display("[TB] abort in T2B of frame 2");
      z0 = zCount; d0 = doneCount;
      applyStimulus(4'd4);
      repeat ((OVL ? 8 : 10) - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_x", int'(x), 15);
      sbq.delete();
      repeat (3) @(negedge clk);
      checkOutput("abort_z", zCount - z0, 1);
      checkOutput("abort_done", doneCount - d0, 0);

      $display("[TB] reset mid-frame");
      applyStimulus(4'd2);
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midreset_x", int'(x), 15);
      checkOutput("midreset_valid", int'(valid), 0);
      checkOutput("midreset_busy", int'(busy), 0);
      checkOutput("midreset_done", int'(done), 0);
      sbq.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      z0 = zCount; d0 = doneCount;
      applyStimulus(4'd1);
      waitIdle();
      checkOutput("postreset_z", zCount - z0, 1);
      checkOutput("postreset_done", doneCount - d0, 1);

      $display("[TB] start while busy");
      z0 = zCount; d0 = doneCount;
      applyStimulus(4'd2);
      for (int i = 0; i < 3; i++) begin
         start = 1'b1;
         count = 4'd5;
         @(negedge clk);
         start = 1'b0;
         @(negedge clk);
      end
      waitIdle();
      checkOutput("rebusy_z", zCount - z0, 2);
      checkOutput("rebusy_done", doneCount - d0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
